// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider producing quotient (lo) and remainder (hi).
// One quotient bit per clock; busy stalls the pipeline, annul drops a flushed divide.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hassign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    counter_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] a_orig_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             div0_reg;
  logic             ready_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   cand;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign a_mag = (hassign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (hassign && b[WIDTH-1]) ? -b : b;

  // The shifted-in bit makes the partial remainder WIDTH+1 bits wide, so the
  // compare/subtract has to be one bit wider than the operands.
  assign cand     = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = cand - {1'b0, divisor_reg};
  assign ge       = (cand >= {1'b0, divisor_reg});
  assign rem_next = ge ? diff[WIDTH-1:0] : cand[WIDTH-1:0];
  assign quo_next = {quo_reg[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      a_orig_reg  <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      div0_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !annul) begin
            divisor_reg <= b_mag;
            rem_reg     <= '0;
            quo_reg     <= a_mag;
            a_orig_reg  <= a;
            sign_q_reg  <= hassign & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r_reg  <= hassign & a[WIDTH-1];
            div0_reg    <= (b == '0);
            counter_reg <= '0;
            state_reg   <= DIV;
          end
        end
        DIV: begin
          if (annul) begin
            state_reg <= IDLE;
          end else begin
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            counter_reg <= counter_reg + 1'b1;
            if (counter_reg == CW'(WIDTH - 1))
              state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          if (!annul) begin
            ready_reg <= 1'b1;
            if (div0_reg) begin
              lo_reg <= '1;
              hi_reg <= a_orig_reg;
            end else begin
              lo_reg <= sign_q_reg ? -quo_reg : quo_reg;
              hi_reg <= sign_r_reg ? -rem_reg : rem_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg != IDLE);
  assign ready = ready_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule
